// File: rtl/fifo_ctrl_param_pkg.sv
// Shared sizing helpers for the parametrised FIFO controller.
// The storage depth and the occupancy-count width are both derived from the pointer width.
package fifo_ctrl_param_pkg;

   localparam int unsigned DefaultDataWidth    = 10;
   localparam int unsigned DefaultAddressWidth = 8;

   function automatic int unsigned fifo_depth(input int unsigned aw);
      return 32'd1 << aw;
   endfunction

   // One extra bit so the count can represent a completely full FIFO.
   function automatic int unsigned count_width(input int unsigned aw);
      return aw + 32'd1;
   endfunction

endpackage

// File: rtl/fifo_ctrl_param_if.sv
// Handshake, threshold and status bundle between the FIFO and its producer/consumer.
// The master side drives the requests; the slave side is the FIFO itself.
interface fifo_ctrl_param_if #(
   parameter int unsigned data_width    = fifo_ctrl_param_pkg::DefaultDataWidth,
   parameter int unsigned address_width = fifo_ctrl_param_pkg::DefaultAddressWidth
) ();

   localparam int unsigned CountWidth = fifo_ctrl_param_pkg::count_width(address_width);

   logic                  wr_enable;
   logic                  rd_enable;
   logic [data_width-1:0] FIFO_data_in;
   logic [CountWidth-1:0] almost_full_thr;
   logic [CountWidth-1:0] almost_empty_thr;
   logic                  err_clear;
   logic [data_width-1:0] FIFO_data_out;
   logic                  data_valid;
   logic [CountWidth-1:0] fifo_count;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic                  overflow_err;
   logic                  underflow_err;

   modport master (
      output wr_enable, rd_enable, FIFO_data_in, almost_full_thr, almost_empty_thr, err_clear,
      input  FIFO_data_out, data_valid, fifo_count, full, empty, almost_full, almost_empty,
             overflow_err, underflow_err
   );

   modport slave (
      input  wr_enable, rd_enable, FIFO_data_in, almost_full_thr, almost_empty_thr, err_clear,
      output FIFO_data_out, data_valid, fifo_count, full, empty, almost_full, almost_empty,
             overflow_err, underflow_err
   );

endinterface

// File: rtl/fifo_ctrl_param_ram_2p.sv
// Two-port storage: one write port and one registered read port.
// The array itself is never reset; only the read-data register is.
module fifo_ctrl_param_ram_2p #(
   parameter int unsigned data_width    = 10,
   parameter int unsigned address_width = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     we,
   input  logic [address_width-1:0] waddr,
   input  logic [data_width-1:0]    wdata,
   input  logic                     re,
   input  logic [address_width-1:0] raddr,
   output logic [data_width-1:0]    rdata
);
   import fifo_ctrl_param_pkg::*;

   logic [data_width-1:0] mem [fifo_depth(address_width)];
   logic [data_width-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read-before-write on an address collision returns the old word, which is what a
   // simultaneous read/write on a full FIFO needs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata_q <= '0;
      end else if (re) begin
         rdata_q <= mem[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/fifo_ctrl_param.sv
// Synchronous FIFO controller with its own pointers, storage, occupancy count,
// threshold flags and sticky overflow/underflow errors.
module fifo_ctrl_param #(
   parameter int unsigned data_width    = 10,
   parameter int unsigned address_width = 8
) (
   input  logic               clk,
   input  logic               reset,
   fifo_ctrl_param_if.slave   bus
);
   import fifo_ctrl_param_pkg::*;

   localparam int unsigned CountWidth = count_width(address_width);
   localparam logic [CountWidth-1:0] DepthCount = {1'b1, {address_width{1'b0}}};

   logic [address_width-1:0] wr_ptr_q, rd_ptr_q;
   logic [CountWidth-1:0]    count_q, count_d;
   logic                     valid_q;
   logic                     ovf_q, ovf_d;
   logic                     udf_q, udf_d;
   logic                     wr_acc, rd_acc;
   logic                     full, empty;

   assign full   = (count_q == DepthCount);
   assign empty  = (count_q == '0);
   assign rd_acc = bus.rd_enable && !empty;
   // A read in the same cycle frees a slot, so a write on a full FIFO still goes through.
   assign wr_acc = bus.wr_enable && (!full || rd_acc);

   always_comb begin
      count_d = count_q;
      unique case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CountWidth'(1);
         2'b01:   count_d = count_q - CountWidth'(1);
         default: count_d = count_q;
      endcase
      // Setting wins over a simultaneous clear.
      ovf_d = (bus.wr_enable && full && !rd_acc) || (ovf_q && !bus.err_clear);
      udf_d = (bus.rd_enable && empty) || (udf_q && !bus.err_clear);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr_q <= wr_ptr_q + address_width'(1);
         if (rd_acc) rd_ptr_q <= rd_ptr_q + address_width'(1);
         count_q <= count_d;
         valid_q <= rd_acc;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   fifo_ctrl_param_ram_2p #(
      .data_width    (data_width),
      .address_width (address_width)
   ) u_ram_2p (
      .clk   (clk),
      .reset (reset),
      .we    (wr_acc),
      .waddr (wr_ptr_q),
      .wdata (bus.FIFO_data_in),
      .re    (rd_acc),
      .raddr (rd_ptr_q),
      .rdata (bus.FIFO_data_out)
   );

   assign bus.data_valid    = valid_q;
   assign bus.fifo_count    = count_q;
   assign bus.full          = full;
   assign bus.empty         = empty;
   assign bus.almost_full   = (count_q >= bus.almost_full_thr);
   assign bus.almost_empty  = (count_q <= bus.almost_empty_thr);
   assign bus.overflow_err  = ovf_q;
   assign bus.underflow_err = udf_q;

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// Randomised and directed bench for fifo_ctrl_param (8-deep, 10-bit) against a queue model.
module tb_fifo_ctrl_param;

   localparam int unsigned Dw    = 10;
   localparam int unsigned Aw    = 3;
   localparam int unsigned Depth = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   fifo_ctrl_param_if #(.data_width(Dw), .address_width(Aw)) bus ();

   fifo_ctrl_param #(.data_width(Dw), .address_width(Aw)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural reference state.
   logic [Dw-1:0] q[$];
   logic [Dw-1:0] m_dout;
   logic          m_valid, m_ovf, m_udf;
   int            af_thr, ae_thr;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      int n;
      n = q.size();
      check_eq({tag, ":count"}, 32'(bus.fifo_count), n);
      check_eq({tag, ":full"}, 32'(bus.full), 32'(n == Depth));
      check_eq({tag, ":empty"}, 32'(bus.empty), 32'(n == 0));
      check_eq({tag, ":almost_full"}, 32'(bus.almost_full), 32'(n >= af_thr));
      check_eq({tag, ":almost_empty"}, 32'(bus.almost_empty), 32'(n <= ae_thr));
      check_eq({tag, ":dout"}, 32'(bus.FIFO_data_out), 32'(m_dout));
      check_eq({tag, ":valid"}, 32'(bus.data_valid), 32'(m_valid));
      check_eq({tag, ":ovf"}, 32'(bus.overflow_err), 32'(m_ovf));
      check_eq({tag, ":udf"}, 32'(bus.underflow_err), 32'(m_udf));
   endtask

   task automatic model_reset();
      q.delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
   endtask

   // One clock: drive request, advance, update model from the FIFO rules, compare.
   task automatic step(input string tag, input logic w, input logic r,
                       input logic [Dw-1:0] d, input logic c);
      int  n;
      logic ra, wa;
      bus.wr_enable        = w;
      bus.rd_enable        = r;
      bus.FIFO_data_in     = d;
      bus.err_clear        = c;
      bus.almost_full_thr  = 4'(af_thr);
      bus.almost_empty_thr = 4'(ae_thr);
      @(posedge clk);
      n  = q.size();
      ra = r && (n > 0);
      wa = w && ((n < Depth) || ra);
      m_ovf   = (w && (n == Depth) && !ra) || (m_ovf && !c);
      m_udf   = (r && (n == 0)) || (m_udf && !c);
      m_valid = ra;
      if (ra) m_dout = q.pop_front();
      if (wa) q.push_back(d);
      #1;
      check_all(tag);
   endtask

   initial begin
      bus.wr_enable        = 1'b0;
      bus.rd_enable        = 1'b0;
      bus.FIFO_data_in     = '0;
      bus.err_clear        = 1'b0;
      af_thr               = 0;
      ae_thr               = 1;
      bus.almost_full_thr  = 4'd0;
      bus.almost_empty_thr = 4'd1;
      model_reset();

      #2 reset = 1'b0;
      #1;
      check_all("reset_thr0");
      af_thr              = 6;
      bus.almost_full_thr = 4'd6;
      #1;
      check_all("reset_thr6");
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      // Fill, then one write too many.
      for (int i = 1; i <= 8; i++) step("fill", 1'b1, 1'b0, 10'(i), 1'b0);
      step("overflow", 1'b1, 1'b0, 10'h0AA, 1'b0);
      check_eq("overflow_flag", 32'(bus.overflow_err), 32'd1);

      // Drain in order, then one read too many.
      for (int i = 1; i <= 8; i++) begin
         step("drain", 1'b0, 1'b1, '0, 1'b0);
         check_eq("drain_order", 32'(bus.FIFO_data_out), i);
      end
      step("underflow", 1'b0, 1'b1, '0, 1'b0);
      step("clear", 1'b0, 1'b0, '0, 1'b1);
      check_eq("cleared_ovf", 32'(bus.overflow_err), 32'd0);

      // Full with simultaneous read/write.
      for (int i = 0; i < 8; i++) step("refill", 1'b1, 1'b0, 10'(8'h10 + i), 1'b0);
      step("full_rw", 1'b1, 1'b1, 10'h3FF, 1'b0);
      for (int i = 0; i < 8; i++) step("drain_rw", 1'b0, 1'b1, '0, 1'b0);
      check_eq("full_rw_word", 32'(bus.FIFO_data_out), 32'h3FF);

      // Empty with simultaneous read/write.
      step("empty_rw", 1'b1, 1'b1, 10'h2C5, 1'b0);
      step("empty_rw_rd", 1'b0, 1'b1, '0, 1'b1);
      check_eq("empty_rw_word", 32'(bus.FIFO_data_out), 32'h2C5);

      // Clear coinciding with a fresh overflow keeps the flag.
      for (int i = 0; i < 8; i++) step("fill2", 1'b1, 1'b0, 10'(i + 3), 1'b0);
      step("ovf_clr", 1'b1, 1'b0, 10'h155, 1'b1);
      check_eq("ovf_set_wins", 32'(bus.overflow_err), 32'd1);

      // Random traffic across many pointer wraps, with moving thresholds.
      for (int i = 0; i < 300; i++) begin
         af_thr = int'($urandom_range(0, 8));
         ae_thr = int'($urandom_range(0, 8));
         step("rand", 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
              10'($urandom), 1'($urandom_range(0, 9) == 0));
      end

      // Reset in the middle of a burst at count 5, right after a read.
      while (q.size() > 0) step("empty_out", 1'b0, 1'b1, '0, 1'b0);
      for (int i = 0; i < 6; i++) step("burst", 1'b1, 1'b0, 10'(10'h100 + i), 1'b0);
      step("burst_rd", 1'b0, 1'b1, '0, 1'b0);
      check_eq("pre_reset_count", 32'(bus.fifo_count), 32'd5);
      bus.wr_enable = 1'b1;
      bus.FIFO_data_in = 10'h3C3;
      #2 reset = 1'b0;
      #1;
      model_reset();
      check_all("async_reset");
      bus.wr_enable = 1'b0;
      bus.rd_enable = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      step("post_reset_wr", 1'b1, 1'b0, 10'h07E, 1'b0);
      step("post_reset_rd", 1'b0, 1'b1, '0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_ctrl_param.md
# fifo_ctrl_param

Parametrised synchronous FIFO that owns its own write/read pointers and storage, replacing the externally-pointed memory used in the FIFO datapath. It sits between the upstream data source and the downstream consumer on the single system clock. It adds occupancy tracking, full/empty flags, programmable almost-full/almost-empty thresholds, one-cycle registered read data with a valid strobe, and sticky overflow/underflow error flags.

## Interface
- data_width, 10, word width in bits
- address_width, 8, pointer width; DEPTH = 2**address_width words
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; 0 = reset asserted
- wr_enable  in  1  write request for FIFO_data_in this cycle
- rd_enable  in  1  read request this cycle
- FIFO_data_in  in  data_width  write data
- almost_full_thr  in  address_width+1  almost_full asserts when count >= value
- almost_empty_thr  in  address_width+1  almost_empty asserts when count <= value
- err_clear  in  1  synchronous clear of sticky error flags
- FIFO_data_out  out  data_width  registered read data
- data_valid  out  1  FIFO_data_out holds a newly read word this cycle
- fifo_count  out  address_width+1  current occupancy, 0..DEPTH
- full  out  1  fifo_count == DEPTH
- empty  out  1  fifo_count == 0
- almost_full  out  1  fifo_count >= almost_full_thr
- almost_empty  out  1  fifo_count <= almost_empty_thr
- overflow_err  out  1  sticky: write attempted while full and not relieved
- underflow_err  out  1  sticky: read attempted while empty

## Operation
- Write accepted (wr_acc) when wr_enable && (!full || rd_acc); word stored at wr_ptr, wr_ptr increments.
- Read accepted (rd_acc) when rd_enable && !empty; word at rd_ptr registered to FIFO_data_out, rd_ptr increments.
- Full + simultaneous rd/wr: both accepted, count unchanged, no error.
- Empty + simultaneous rd/wr: read rejected, underflow_err set, write accepted, count 1.
- wr_enable && full && !rd_acc: write dropped, overflow_err set, no state change.
- Pointers are address_width bits and wrap DEPTH-1 -> 0 naturally; count is the sole full/empty source.
- Count: +1 on wr_acc only, -1 on rd_acc only, unchanged otherwise.
- Flags full/empty/almost_* combinational from registered fifo_count and threshold inputs; thresholds may change any cycle.
- Errors: set on condition, cleared by err_clear; set wins over simultaneous clear.
- FIFO_data_out holds its last value when no read is accepted.

## Timing
- Reset (reset=0, async): wr_ptr=0, rd_ptr=0, fifo_count=0, FIFO_data_out=0, data_valid=0, overflow_err=0, underflow_err=0; hence empty=1, full=0, almost_empty=1, almost_full=(almost_full_thr==0). Storage not reset.
- Reset release sampled at clk; first operation on the first rising edge with reset=1.
- Read latency: rd_acc at edge N -> FIFO_data_out and data_valid=1 valid after edge N; data_valid=0 the following cycle unless another read is accepted.
- Write-to-read: word written at edge N readable by rd_acc at edge N+1 (empty deasserts after edge N).
- Flags update in the cycle after the edge that changes fifo_count.
- Reset asserted mid-burst: all in-flight operations discarded, outputs return to reset values immediately.

## Structure
- Shared package: DEPTH derivation, count width (address_width+1), no typedefs beyond these constants.
- One sub-module: ram_2p, one write port and one synchronous read port, data_width x DEPTH, no reset on the array; control, count, flags and errors in fifo_ctrl_param.

## Test plan
- address_width=3: reset, write 8 words 0x001..0x008 -> full=1, fifo_count=8, almost_full=1 with thr=6; 9th write -> overflow_err=1, count stays 8.
- Read 8 words from full -> FIFO_data_out 0x001..0x008 one cycle after each rd_acc, data_valid pulses, empty=1 at end; extra read -> underflow_err=1.
- Full, rd_enable=wr_enable=1 with 0x3FF -> count stays 8, no error, 0x3FF read out 8 reads later.
- Empty, simultaneous rd/wr 0x2C5 -> underflow_err=1, count=1, next read returns 0x2C5.
- 20 writes/reads interleaved across pointer wrap -> data order preserved; err_clear with no new error clears flags; err_clear plus new overflow -> overflow_err stays 1.
- Assert reset at count=5 mid-burst -> count=0, empty=1, data_valid=0, FIFO_data_out=0 without waiting for clk.
